conv_layer_sched: RTL and testbench

- Sequencer for one conv-layer engine: parsing/zero-pad, weight_ctrl, 12-MAC bank, four adder trees, four post-processing lanes.
- Engine computes 4 output filters per pass; this block runs NUM_GROUPS passes to cover all filters.
- Per pass it launches the engine, supplies the 4 biases for that group, counts finished output pixels, waits for pipeline drain, then steps to the next group.
- Sits between the top-level start/config interface and the layer datapath.

---
 rtl/conv_layer_sched.sv | 171 +++++++++++++++++
 tb/tb_conv_layer_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
// Layer sequencer: launches the conv engine once per 4-filter group, feeds that
// group's biases, counts finished pixels, waits for pipeline drain, then steps on.
module conv_layer_sched #(
  parameter int NUM_GROUPS = 4,
  parameter int OUT_PIX    = 64,
  parameter int DRAIN_CYC  = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_cfg_we,
  input  logic [4:0]       i_cfg_addr,
  input  logic [15:0]      i_cfg_bias,
  input  logic             i_out_vld,
  output logic             o_layer_start,
  output logic [15:0]      o_bias0,
  output logic [15:0]      o_bias1,
  output logic [15:0]      o_bias2,
  output logic [15:0]      o_bias3,
  output logic [2:0]       o_group,
  output logic [CNT_W-1:0] o_pix_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(OUT_PIX - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [2:0]       GRP_LAST   = 3'(NUM_GROUPS - 1);

  state_e           state_q, state_d;
  logic [2:0]       grp_q, grp_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             timeout_q, timeout_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [15:0]      bias_q [4];
  logic [15:0]      bias_d [4];
  logic             load_bias;
  logic [2:0]       ld_grp;
  logic             tbl_we;

  // Bias table is not reset; sized for the largest group count so any 5-bit index is legal.
  logic [15:0]      tbl_q [32];

  assign tbl_we = (state_q == S_IDLE) && i_cfg_we &&
                  ({1'b0, i_cfg_addr} < 6'(4 * NUM_GROUPS));

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[i_cfg_addr] <= i_cfg_bias;
  end

  // cyc_q is the watchdog in RUN and the drain counter in DRAIN.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    pix_d     = pix_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    load_bias = 1'b0;
    ld_grp    = grp_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_LAUNCH;
          grp_d     = 3'd0;
          timeout_d = 1'b0;
          load_bias = 1'b1;
          ld_grp    = 3'd0;
        end
      end
      S_LAUNCH: begin
        pix_d   = '0;
        cyc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (i_out_vld) begin
          cyc_d = '0;
          if (pix_q >= PIX_LAST) begin
            pix_d   = '0;
            state_d = S_DRAIN;
          end else if (pix_q != CNT_MAX) begin
            pix_d = pix_q + CNT_W'(1);
          end
        end else if (cyc_q >= WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
          grp_d     = 3'd0;
          pix_d     = '0;
          cyc_d     = '0;
        end else if (cyc_q != CNT_MAX) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cyc_q >= DRAIN_LAST) begin
          cyc_d = '0;
          if (grp_q >= GRP_LAST) begin
            state_d = S_DONE;
          end else begin
            grp_d     = grp_q + 3'd1;
            ld_grp    = grp_q + 3'd1;
            load_bias = 1'b1;
            state_d   = S_LAUNCH;
          end
        end else if (cyc_q != CNT_MAX) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grp_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // Table read sees the pre-write contents when a write coincides with start.
    for (int k = 0; k < 4; k++) begin
      bias_d[k] = load_bias ? tbl_q[{ld_grp, 2'(k)}] : bias_q[k];
    end

    start_d = (state_d == S_LAUNCH);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      grp_q     <= 3'd0;
      pix_q     <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < 4; k++) bias_q[k] <= 16'h0000;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      pix_q     <= pix_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      for (int k = 0; k < 4; k++) bias_q[k] <= bias_d[k];
    end
  end

  assign o_layer_start = start_q;
  assign o_bias0       = bias_q[0];
  assign o_bias1       = bias_q[1];
  assign o_bias2       = bias_q[2];
  assign o_bias3       = bias_q[3];
  assign o_group       = grp_q;
  assign o_pix_cnt     = pix_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed-sequence bench for conv_layer_sched with randomized strobe gaps and
// bias data, checked against a bias-table model and pass/pixel bookkeeping.
module tb_conv_layer_sched;
  localparam int NG        = 4;
  localparam int OUT_PIX   = 64;
  localparam int DRAIN_CYC = 8;
  localparam int TIMEOUT   = 1024;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_start = 1'b0;
  logic             i_cfg_we = 1'b0;
  logic [4:0]       i_cfg_addr = '0;
  logic [15:0]      i_cfg_bias = '0;
  logic             i_out_vld = 1'b0;
  logic             o_layer_start;
  logic [15:0]      o_bias0, o_bias1, o_bias2, o_bias3;
  logic [2:0]       o_group;
  logic [CNT_W-1:0] o_pix_cnt;
  logic             o_busy, o_done, o_timeout;
  logic [15:0]      ob [4];

  conv_layer_sched #(
    .NUM_GROUPS(NG), .OUT_PIX(OUT_PIX), .DRAIN_CYC(DRAIN_CYC),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_cfg_we(i_cfg_we),
    .i_cfg_addr(i_cfg_addr), .i_cfg_bias(i_cfg_bias), .i_out_vld(i_out_vld),
    .o_layer_start(o_layer_start), .o_bias0(o_bias0), .o_bias1(o_bias1),
    .o_bias2(o_bias2), .o_bias3(o_bias3), .o_group(o_group),
    .o_pix_cnt(o_pix_cnt), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  assign ob[0] = o_bias0;
  assign ob[1] = o_bias1;
  assign ob[2] = o_bias2;
  assign ob[3] = o_bias3;

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          n_launch = 0;
  int          n_done = 0;
  logic [15:0] mdl [4*NG];

  always @(negedge clk) begin
    if (o_layer_start === 1'b1) n_launch++;
    if (o_done === 1'b1) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bias(input string tag, input int g);
    for (int k = 0; k < 4; k++) chk(tag, {16'h0, ob[k]}, {16'h0, mdl[4*g+k]});
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {o_layer_start, o_busy, o_done, o_timeout, o_group}, 0);
    chk(tag, o_pix_cnt, 0);
    for (int k = 0; k < 4; k++) chk(tag, ob[k], 0);
  endtask

  task automatic cfg_write(input int addr, input logic [15:0] data);
    i_cfg_we = 1'b1;
    i_cfg_addr = 5'(addr);
    i_cfg_bias = data;
    tick();
    i_cfg_we = 1'b0;
    mdl[addr] = data;
  endtask

  task automatic start_layer();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Entered just after the edge that put the engine into its launch cycle for group g.
  task automatic do_pass(input int g, input int n, input int gmin, input int gmax, input bit noise);
    int gap;
    chk("launch_pulse", o_layer_start, 1);
    chk("launch_group", o_group, g);
    chk("launch_busy", o_busy, 1);
    chk_bias("launch_bias", g);
    i_out_vld = 1'($urandom_range(0, 1));
    tick();
    i_out_vld = 1'b0;
    chk("run_pix0", o_pix_cnt, 0);
    chk("run_no_launch", o_layer_start, 0);
    for (int p = 0; p < n; p++) begin
      gap = $urandom_range(gmin, gmax);
      for (int c = 0; c < gap; c++) begin
        if (noise) begin
          i_start = 1'($urandom_range(0, 1));
          i_cfg_we = 1'b1;
          i_cfg_addr = 5'd0;
          i_cfg_bias = 16'hFFFF;
        end
        tick();
        i_start = 1'b0;
        i_cfg_we = 1'b0;
      end
      if (gap > 0) chk("pix_hold", o_pix_cnt, p);
      i_out_vld = 1'b1;
      tick();
      i_out_vld = 1'b0;
      if (p < OUT_PIX - 1) chk("pix_cnt", o_pix_cnt, p + 1);
      else chk("pix_drain_zero", o_pix_cnt, 0);
    end
    if (n < OUT_PIX) return;
    for (int d = 0; d < DRAIN_CYC - 1; d++) begin
      i_out_vld = 1'($urandom_range(0, 1));
      tick();
      i_out_vld = 1'b0;
      chk("drain_busy", o_busy, 1);
      chk("drain_pix", o_pix_cnt, 0);
      chk("drain_quiet", {o_layer_start, o_done}, 0);
      chk_bias("drain_bias", g);
    end
    tick();
    if (g == NG - 1) begin
      chk("done_pulse", o_done, 1);
      chk("done_no_launch", o_layer_start, 0);
      tick();
      chk("done_clear", o_done, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_group", o_group, 0);
    end else begin
      chk("next_launch", o_layer_start, 1);
      chk("next_no_done", o_done, 0);
    end
  endtask

  // Entered in the launch cycle of pass 0; completes all passes.
  task automatic run_passes(input int gmin, input int gmax, input bit noise);
    int l0, d0;
    l0 = n_launch;
    d0 = n_done;
    for (int g = 0; g < NG; g++) do_pass(g, OUT_PIX, gmin, gmax, noise && (g == 1));
    chk("layer_launches", n_launch - l0, NG);
    chk("layer_dones", n_done - d0, 1);
  endtask

  initial begin
    int d0;
    tick();
    tick();
    chk_all_zero("reset_state");
    rstn = 1'b1;
    tick();

    for (int k = 0; k < 4*NG; k++) cfg_write(k, 16'(16 * k));
    i_out_vld = 1'b1;
    tick();
    i_out_vld = 1'b0;
    chk("idle_vld_ignored", o_pix_cnt, 0);
    chk("idle_vld_no_busy", o_busy, 0);

    // Back-to-back strobes, then every-other-cycle strobes.
    start_layer();
    run_passes(0, 0, 1'b0);
    start_layer();
    run_passes(1, 1, 1'b0);

    // Random biases; start and table writes while busy must be ignored.
    for (int k = 0; k < 4*NG; k++) cfg_write(k, 16'($urandom_range(0, 65535)));
    start_layer();
    run_passes(1, 3, 1'b1);
    start_layer();
    run_passes(0, 2, 1'b0);

    // Write and start in the same cycle: launch sees the old entry.
    cfg_write(0, 16'h1111);
    i_start = 1'b1;
    i_cfg_we = 1'b1;
    i_cfg_addr = 5'd0;
    i_cfg_bias = 16'hAAAA;
    tick();
    i_start = 1'b0;
    i_cfg_we = 1'b0;
    chk("rbw_bias0", o_bias0, 16'h1111);
    do_pass(0, OUT_PIX, 0, 1, 1'b0);
    mdl[0] = 16'hAAAA;
    for (int g = 1; g < NG; g++) do_pass(g, OUT_PIX, 0, 1, 1'b0);
    start_layer();
    chk("rbw_new_bias0", o_bias0, 16'hAAAA);
    run_passes(0, 1, 1'b0);

    // Watchdog: strobes stop after 10 pixels of pass 1.
    start_layer();
    d0 = n_done;
    do_pass(0, OUT_PIX, 0, 1, 1'b0);
    do_pass(1, 10, 0, 1, 1'b0);
    for (int c = 0; c < TIMEOUT - 1; c++) tick();
    chk("wd_not_yet", o_timeout, 0);
    chk("wd_still_busy", o_busy, 1);
    tick();
    chk("wd_timeout", o_timeout, 1);
    chk("wd_idle", o_busy, 0);
    tick();
    chk("wd_sticky", o_timeout, 1);
    chk("wd_no_done", n_done - d0, 0);
    start_layer();
    chk("wd_cleared", o_timeout, 0);
    run_passes(0, 1, 1'b0);

    // Asynchronous reset in the middle of pass 2.
    start_layer();
    d0 = n_done;
    do_pass(0, OUT_PIX, 0, 1, 1'b0);
    do_pass(1, OUT_PIX, 0, 1, 1'b0);
    do_pass(2, 20, 0, 1, 1'b0);
    rstn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk_all_zero("post_reset");
    chk("reset_no_done", n_done - d0, 0);
    start_layer();
    run_passes(0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
